// File: rtl/tc_load_if.sv
// tc_load_if: request/beat handshake between the load sequencer and the AXI adapter
interface tc_load_if;
  logic [2:0]  sel;
  logic        request_valid;
  logic        axi_valid;
  logic [31:0] axi_burst_id;
  logic        axi_finish;
  modport master (output sel, request_valid, input axi_valid, axi_burst_id, axi_finish);
  modport slave  (input sel, request_valid, output axi_valid, axi_burst_id, axi_finish);
endinterface

// File: rtl/tc_load_sequencer.sv
// tc_load_sequencer: loads C, A, B over AXI with beat-count/order/timeout checks, then pulses compute_go
module tc_load_sequencer #(
  parameter int NBEAT_C = 8,
  parameter int NBEAT_A = 4,
  parameter int NBEAT_B = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  tc_load_if.master        bus,
  output logic             busy,
  output logic             compute_go,
  output logic             error,
  output logic [1:0]       err_code
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [3:0] {IDLE, REQ_C, WAIT_C, REQ_A, WAIT_A, REQ_B, WAIT_B, GO, ERR} state_t;
  state_t state, nxt_req;
  logic [31:0] beat_cnt, nbeat, cnt_eff;
  logic [TW-1:0] tmo_cnt;
  logic id_bad, beat, tmo;
  logic [1:0] err_c;
  logic [2:0] nxt_sel;
  always_comb begin
    nbeat = state == WAIT_C ? 32'(NBEAT_C) : state == WAIT_A ? 32'(NBEAT_A) : 32'(NBEAT_B);
    id_bad = bus.axi_valid && bus.axi_burst_id != beat_cnt;
    beat = bus.axi_valid && !id_bad;
    cnt_eff = beat_cnt + 32'(beat);
    tmo = !bus.axi_valid && tmo_cnt <= TW'(1);
    err_c = id_bad ? 2'b10
          : (beat && beat_cnt == nbeat) || (bus.axi_finish && cnt_eff != nbeat) ? 2'b01
          : tmo ? 2'b11 : 2'b00;
    nxt_req = state == WAIT_C ? REQ_A : state == WAIT_A ? REQ_B : GO;
    nxt_sel = state == WAIT_C ? 3'b100 : state == WAIT_A ? 3'b010 : 3'b000;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.sel <= '0;
      bus.request_valid <= 1'b0;
      busy <= 1'b0;
      compute_go <= 1'b0;
      error <= 1'b0;
      err_code <= '0;
      beat_cnt <= '0;
      tmo_cnt <= '0;
    end else if (abort) begin
      state <= IDLE;
      bus.sel <= '0;
      bus.request_valid <= 1'b0;
      busy <= 1'b0;
      compute_go <= 1'b0;
      error <= 1'b0;
      err_code <= '0;
      beat_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      bus.request_valid <= 1'b0;
      compute_go <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= REQ_C;
          bus.sel <= 3'b001;
          bus.request_valid <= 1'b1;
          busy <= 1'b1;
        end
        REQ_C, REQ_A, REQ_B: begin
          state <= state == REQ_C ? WAIT_C : state == REQ_A ? WAIT_A : WAIT_B;
          beat_cnt <= '0;
          tmo_cnt <= TW'(TIMEOUT - 1);
        end
        WAIT_C, WAIT_A, WAIT_B: begin
          if (err_c != 2'b00) begin
            state <= ERR;
            bus.sel <= '0;
            busy <= 1'b0;
            error <= 1'b1;
            err_code <= err_c;
          end else if (bus.axi_finish) begin
            state <= nxt_req;
            bus.sel <= nxt_sel;
            bus.request_valid <= nxt_req != GO;
            compute_go <= nxt_req == GO;
          end else if (beat) begin
            beat_cnt <= cnt_eff;
            tmo_cnt <= TW'(TIMEOUT - 1);
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        GO: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        ERR: if (start) begin
          state <= IDLE;
          error <= 1'b0;
          err_code <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
